// File: rtl/filter_pad_pkg.sv
// Shared types and constants for the zero-padding frame sequencer.
package filter_pad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_LEFT,
    S_DATA,
    S_RIGHT,
    S_BOTTOM,
    S_DRAIN
  } pad_state_t;

  typedef struct packed {
    int unsigned b;
    int unsigned pw;
    int unsigned total;
    int unsigned drain;
  } pad_dims_t;

  localparam logic [23:0] PAD_PIXEL = 24'h0;

  function automatic pad_dims_t pad_dims(input int unsigned w, input int unsigned h,
                                         input int unsigned k);
    pad_dims_t d;
    d.b     = (k - 1) / 2;
    d.pw    = w + 2 * d.b;
    d.total = (h + 2 * d.b) * d.pw;
    d.drain = d.b * d.pw + d.b;
    return d;
  endfunction

endpackage

// File: rtl/filter_pad_ctrl.sv
// Wraps the demosaic pixel stream in a B-pixel zero border for the kernel filter,
// then flushes the filter pipeline. Optional flush phase: FILTER_PAD_DRAIN_EN.
module filter_pad_ctrl
  import filter_pad_pkg::*;
#(
  parameter int unsigned width      = 320,
  parameter int unsigned height     = 240,
  parameter int unsigned kernelSize = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        newFrame,
  input  logic        iValid,
  input  logic [23:0] iData,
  output logic        oReady,
  output logic        oValid,
  output logic [23:0] oData,
  output logic        oPipeEn,
  output logic        oBusy,
  output logic        oOverflow,
  output logic        oDone
);

  localparam pad_dims_t   DIMS    = pad_dims(width, height, kernelSize);
  localparam int unsigned B       = DIMS.b;
  localparam int unsigned PW      = DIMS.pw;
  localparam int unsigned COL_MAX = (B * PW > width) ? B * PW : width;
  localparam int unsigned COL_W   = $clog2(COL_MAX + 1);
  localparam int unsigned ROW_W   = $clog2(height + 1);

  localparam logic [COL_W-1:0] BAND_LAST = COL_W'(B * PW - 1);
  localparam logic [COL_W-1:0] SIDE_LAST = COL_W'(B - 1);
  localparam logic [COL_W-1:0] PIX_LAST  = COL_W'(width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(height - 1);

  pad_state_t        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic [23:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

`ifdef FILTER_PAD_DRAIN_EN
  localparam int unsigned      DRN   = DIMS.drain;
  localparam int unsigned      DRN_W = $clog2(DRN + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRN);

  logic [DRN_W-1:0]  drain_q, drain_d;
  logic              pipe_q, pipe_d;
`else
  logic              pend_q, pend_d;
`endif

  // newFrame is registered and only accepted while idle (busy stays high through
  // the done cycle, so a request coincident with oDone is dropped).
  assign start_d = newFrame & ~busy_q;
  assign oReady  = (state_q == S_DATA);
  assign ovf_d   = iValid & (state_q != S_DATA);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    data_d  = PAD_PIXEL;
    done_d  = 1'b0;
`ifdef FILTER_PAD_DRAIN_EN
    drain_d = drain_q;
    pipe_d  = 1'b0;
`else
    pend_d  = 1'b0;
    done_d  = pend_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_TOP;
          col_d   = '0;
          row_d   = '0;
`ifdef FILTER_PAD_DRAIN_EN
          drain_d = '0;
`endif
        end
      end

      S_TOP: begin
        valid_d = 1'b1;
        if (col_q == BAND_LAST) begin
          col_d   = '0;
          state_d = S_LEFT;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      S_LEFT: begin
        valid_d = 1'b1;
        if (col_q == SIDE_LAST) begin
          col_d   = '0;
          state_d = S_DATA;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      S_DATA: begin
        if (iValid) begin
          valid_d = 1'b1;
          data_d  = iData;
          if (col_q == PIX_LAST) begin
            col_d   = '0;
            state_d = S_RIGHT;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      S_RIGHT: begin
        valid_d = 1'b1;
        if (col_q == SIDE_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = S_BOTTOM;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_LEFT;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      S_BOTTOM: begin
        valid_d = 1'b1;
        if (col_q == BAND_LAST) begin
          col_d = '0;
`ifdef FILTER_PAD_DRAIN_EN
          drain_d = '0;
          state_d = S_DRAIN;
`else
          pend_d  = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          col_d = col_q + 1'b1;
        end
      end

`ifdef FILTER_PAD_DRAIN_EN
      // Step 0 is the idle gap after the last pad pixel; steps 1..DRN enable the filter.
      S_DRAIN: begin
        pipe_d = (drain_q != '0);
        if (drain_q == DRN_LAST) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

`ifdef FILTER_PAD_DRAIN_EN
  assign busy_d = (state_q != S_IDLE);
`else
  assign busy_d = (state_q != S_IDLE) | pend_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      start_q <= start_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

`ifdef FILTER_PAD_DRAIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_q <= '0;
      pipe_q  <= 1'b0;
    end else begin
      drain_q <= drain_d;
      pipe_q  <= pipe_d;
    end
  end

  assign oPipeEn = pipe_q;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign oPipeEn = 1'b0;
`endif

  assign oValid    = valid_q;
  assign oData     = data_q;
  assign oBusy     = busy_q;
  assign oOverflow = ovf_q;
  assign oDone     = done_q;

endmodule

// File: tb/tb_filter_pad_ctrl.sv
// Self-checking bench for filter_pad_ctrl (width=4, height=2, kernelSize=3).
module tb_filter_pad_ctrl;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int K     = 3;
  localparam int B     = (K - 1) / 2;
  localparam int PW    = W + 2 * B;
  localparam int TOTAL = (H + 2 * B) * PW;
  localparam int DRN   = B * PW + B;
  // Cycle numbering: cycle c is the interval after the c-th rising edge, edge 0 samples newFrame.
  localparam int FIRST_V = 2;
  localparam int LAST_V  = FIRST_V + TOTAL - 1;
`ifdef FILTER_PAD_DRAIN_EN
  localparam int PIPE_N   = DRN;
  localparam int DONE_OFS = DRN + 1;
`else
  localparam int PIPE_N   = 0;
  localparam int DONE_OFS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, newFrame, iValid;
  logic [23:0] iData;
  logic        oReady, oValid, oPipeEn, oBusy, oOverflow, oDone;
  logic [23:0] oData;

  filter_pad_ctrl #(.width(W), .height(H), .kernelSize(K)) dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oValid(oValid), .oData(oData), .oPipeEn(oPipeEn), .oBusy(oBusy),
    .oOverflow(oOverflow), .oDone(oDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] out_q[$];
  logic [23:0] exp_px[$];
  logic [23:0] exp_frame[$];
  int first_v, last_v, pipe_n, first_pipe, done_n, done_cyc, busy_fall, ovf_n;
  bit timeout;
  bit ready_at[0:15];

  // Reference frame from the padding rules: zero bands, zero side columns, pixels in order.
  task automatic build_frame();
    exp_frame = {};
    for (int i = 0; i < B * PW; i++) exp_frame.push_back(24'h0);
    for (int r = 0; r < H; r++) begin
      for (int i = 0; i < B; i++) exp_frame.push_back(24'h0);
      for (int c = 0; c < W; c++) exp_frame.push_back(exp_px[r * W + c]);
      for (int i = 0; i < B; i++) exp_frame.push_back(24'h0);
    end
    for (int i = 0; i < B * PW; i++) exp_frame.push_back(24'h0);
  endtask

  // Drives one frame as a well-behaved upstream source and records what the DUT emitted.
  task automatic run_frame(input int gap_after, input int gap_len, input bit rnd,
                           input int ovf_from, input int ovf_to, input int nf_busy_at,
                           input bit nf_on_done);
    int ec, accepted, gap_left;
    bit seen_busy, want;
    logic [23:0] pix;
    out_q = {}; exp_px = {};
    first_v = -1; last_v = -1; pipe_n = 0; first_pipe = -1; done_n = 0; done_cyc = -1;
    busy_fall = -1; ovf_n = 0; timeout = 1'b0; seen_busy = 1'b0;
    for (int i = 0; i < 16; i++) ready_at[i] = 1'b0;
    accepted = 0; gap_left = gap_len;
    @(negedge clk);
    newFrame = 1'b1; iValid = 1'b0;
    ec = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      newFrame = 1'b0;
      if (ec < 16) ready_at[ec] = oReady;
      if (oValid) begin
        out_q.push_back(oData);
        if (first_v < 0) first_v = ec;
        last_v = ec;
      end
      if (oPipeEn) begin
        pipe_n++;
        if (first_pipe < 0) first_pipe = ec;
      end
      if (oDone) begin
        done_n++;
        done_cyc = ec;
        if (nf_on_done) newFrame = 1'b1;
      end
      if (oOverflow) ovf_n++;
      if (oBusy) seen_busy = 1'b1;
      else if (seen_busy && busy_fall < 0) busy_fall = ec;
      if (ec + 1 == nf_busy_at) newFrame = 1'b1;
      iValid = 1'b0;
      if (oReady) begin
        want = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (accepted == gap_after && gap_left > 0) begin
          want = 1'b0;
          gap_left--;
        end
        if (want) begin
          pix = rnd ? 24'($urandom) : 24'(accepted + 1);
          iValid = 1'b1;
          iData = pix;
          exp_px.push_back(pix);
          accepted++;
        end
      end
      if (ec + 1 >= ovf_from && ec + 1 <= ovf_to && !iValid) begin
        iValid = 1'b1;
        iData = 24'hABCDEF;
      end
      ec++;
      if (busy_fall >= 0 && ec > busy_fall + 2) break;
    end
    iValid = 1'b0; newFrame = 1'b0;
    if (busy_fall < 0) timeout = 1'b1;
    while (exp_px.size() < W * H) exp_px.push_back(24'h0);
    build_frame();
  endtask

  task automatic check_content(input string name);
    int bad;
    bad = -1;
    checks++;
    if (out_q.size() != TOTAL) begin
      failures++;
      $display("FAIL %s_count: got %0d valid pixels, expected %0d", name, out_q.size(), TOTAL);
    end
    checks++;
    for (int i = 0; i < TOTAL && i < out_q.size(); i++)
      if (bad < 0 && out_q[i] !== exp_frame[i]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_data: pixel %0d got %h, expected %h", name, bad, out_q[bad], exp_frame[bad]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({oReady, oValid, oData, oPipeEn, oBusy, oOverflow, oDone} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {oReady, oValid, oData, oPipeEn, oBusy, oOverflow, oDone});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    newFrame = 1'b1;
    @(negedge clk);
    newFrame = 1'b0;
    iValid = 1'b1; iData = 24'h123456;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({oReady, oValid, oData, oPipeEn, oBusy, oOverflow, oDone} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %b, expected all zero",
               {oReady, oValid, oData, oPipeEn, oBusy, oOverflow, oDone});
    end
    @(negedge clk);
    reset = 1'b0; iValid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (oBusy !== 1'b0 || oValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle: busy=%b valid=%b, expected 0 0", oBusy, oValid);
    end
    run_frame(-1, 0, 1'b0, -1, -1, -1, 1'b0);
    check_content("reset_refill");
  endtask

  task automatic test_stream();
    run_frame(-1, 0, 1'b0, -1, -1, -1, 1'b0);
    checks++;
    if (timeout) begin
      failures++;
      $display("FAIL stream_timeout: frame did not complete, expected completion");
    end
    check_content("stream");
    checks++;
    if (first_v != FIRST_V || last_v != LAST_V) begin
      failures++;
      $display("FAIL stream_span: valid cycles %0d..%0d, expected %0d..%0d",
               first_v, last_v, FIRST_V, LAST_V);
    end
    checks++;
    if (ready_at[7] !== 1'b0 || ready_at[8] !== 1'b1 || ready_at[3] !== 1'b0) begin
      failures++;
      $display("FAIL stream_ready: ready@3,7,8=%b%b%b, expected 001",
               ready_at[3], ready_at[7], ready_at[8]);
    end
    checks++;
    if (pipe_n != PIPE_N || (PIPE_N > 0 && first_pipe != LAST_V + 2)) begin
      failures++;
      $display("FAIL stream_pipe: %0d cycles from %0d, expected %0d from %0d",
               pipe_n, first_pipe, PIPE_N, LAST_V + 2);
    end
    checks++;
    if (done_n != 1 || done_cyc != LAST_V + DONE_OFS) begin
      failures++;
      $display("FAIL stream_done: %0d pulses at %0d, expected 1 at %0d",
               done_n, done_cyc, LAST_V + DONE_OFS);
    end
    checks++;
    if (busy_fall != done_cyc + 1) begin
      failures++;
      $display("FAIL stream_busy: fell at %0d, expected %0d", busy_fall, done_cyc + 1);
    end
  endtask

  task automatic test_gap();
    run_frame(2, 3, 1'b0, -1, -1, -1, 1'b0);
    check_content("gap");
    checks++;
    if (last_v != LAST_V + 3 || done_cyc != LAST_V + 3 + DONE_OFS) begin
      failures++;
      $display("FAIL gap_timing: last=%0d done=%0d, expected %0d %0d",
               last_v, done_cyc, LAST_V + 3, LAST_V + 3 + DONE_OFS);
    end
  endtask

  task automatic test_overflow();
    run_frame(-1, 0, 1'b0, 3, 5, -1, 1'b0);
    check_content("overflow");
    checks++;
    if (ovf_n != 3) begin
      failures++;
      $display("FAIL overflow_pulses: got %0d, expected 3", ovf_n);
    end
    checks++;
    if (last_v != LAST_V) begin
      failures++;
      $display("FAIL overflow_last: got %0d, expected %0d", last_v, LAST_V);
    end
  endtask

  task automatic test_newframe_busy();
    int extra;
    run_frame(-1, 0, 1'b0, 10, -1, 12, 1'b1);
    check_content("busy_nf");
    checks++;
    if (done_n != 1 || done_cyc != LAST_V + DONE_OFS) begin
      failures++;
      $display("FAIL busy_nf_done: %0d pulses at %0d, expected 1 at %0d",
               done_n, done_cyc, LAST_V + DONE_OFS);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (oBusy || oValid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_nf_restart: %0d active cycles after done, expected 0", extra);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 0, 1'b1, -1, -1, -1, 1'b0);
      check_content("random");
      checks++;
      if (done_n != 1 || done_cyc != last_v + DONE_OFS || pipe_n != PIPE_N || ovf_n != 0) begin
        failures++;
        $display("FAIL random_tail: done=%0d@%0d pipe=%0d ovf=%0d, expected 1@%0d %0d 0",
                 done_n, done_cyc, pipe_n, ovf_n, last_v + DONE_OFS, PIPE_N);
      end
    end
  endtask

  initial begin
    reset = 1'b1; newFrame = 1'b0; iValid = 1'b0; iData = '0;
    #1;
    test_reset();
    test_stream();
    test_gap();
    test_overflow();
    test_newframe_busy();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
